// File: rtl/shift_add_multiplier_if.sv
// Operand-load / control / result bundle for shift_add_multiplier.
// The master side (operand entry logic) drives loads, Run and Signed;
// the slave side (the multiplier) returns the product halves and status.
interface shift_add_multiplier_if #(
    parameter int WIDTH = 8
);
    logic             LoadA;
    logic             LoadB;
    logic             Run;
    logic             Signed;
    logic [WIDTH-1:0] Din;
    logic [WIDTH-1:0] Aval;
    logic [WIDTH-1:0] Bval;
    logic             X;
    logic             Busy;
    logic             Done;
    logic [2:0]       State;

    modport master (
        output LoadA, LoadB, Run, Signed, Din,
        input  Aval, Bval, X, Busy, Done, State
    );

    modport slave (
        input  LoadA, LoadB, Run, Signed, Din,
        output Aval, Bval, X, Busy, Done, State
    );
endinterface

// File: rtl/shift_add_multiplier.sv
// Sequential shift-add multiplier: FSM, iteration counter and {X, A, B}
// datapath. One ADD/SHIFT pair per multiplier bit, product in {A, B}.
// Optional feature macro: MULT_SIGNED_EN -- when defined the Signed input
// selects two's-complement operation; when undefined every run is unsigned.
module shift_add_multiplier #(
    parameter int WIDTH = 8
) (
    input  logic                     Clk,
    input  logic                     Reset,
    shift_add_multiplier_if.slave    bus
);
    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLEAR = 3'd1,
        ADD   = 3'd2,
        SHIFT = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, b_q, m_q;
    logic             x_q;
    logic [CW-1:0]    cnt_q;
    logic             mode_q;   // 1 = signed run, latched in CLEAR

    logic             last;
    logic [WIDTH:0]   a_ext, m_ext, sum;

    assign last = (cnt_q == LAST);

    // Sign- or zero-extend A and M; the final signed iteration subtracts
    // because the multiplier's top bit carries negative weight.
    always_comb begin
        a_ext = mode_q ? {a_q[WIDTH-1], a_q} : {1'b0, a_q};
        m_ext = mode_q ? {m_q[WIDTH-1], m_q} : {1'b0, m_q};
        sum   = (mode_q && last) ? (a_ext - m_ext) : (a_ext + m_ext);
    end

    // State register.
    always_ff @(posedge Clk) begin
        if (Reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Next-state: counter-driven ADD/SHIFT loop; DONE waits for Run to drop.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.Run) state_d = CLEAR;
            CLEAR:   state_d = ADD;
            ADD:     state_d = SHIFT;
            SHIFT:   state_d = last ? DONE : ADD;
            DONE:    if (!bus.Run) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath: operand loads when idle/done, accumulate and shift while busy.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            a_q    <= '0;
            b_q    <= '0;
            m_q    <= '0;
            x_q    <= 1'b0;
            cnt_q  <= '0;
            mode_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (bus.LoadA) m_q <= bus.Din;
                    if (bus.LoadB) begin
                        b_q <= bus.Din;
                        a_q <= '0;
                        x_q <= 1'b0;
                    end
                end
                CLEAR: begin
                    a_q   <= '0;
                    x_q   <= 1'b0;
                    cnt_q <= '0;
`ifdef MULT_SIGNED_EN
                    mode_q <= bus.Signed;
`else
                    mode_q <= 1'b0;
`endif
                end
                ADD: begin
                    if (b_q[0]) begin
                        a_q <= sum[WIDTH-1:0];
                        x_q <= sum[WIDTH];
                    end
                end
                SHIFT: begin
                    a_q <= {x_q, a_q[WIDTH-1:1]};
                    b_q <= {a_q[0], b_q[WIDTH-1:1]};
                    // Signed keeps X as the replicated sign; unsigned drains it.
                    if (!mode_q) x_q <= 1'b0;
                    if (!last)   cnt_q <= cnt_q + 1'b1;
                end
                default: ;
            endcase
        end
    end

`ifndef MULT_SIGNED_EN
    logic unused_signed;
    assign unused_signed = bus.Signed;
`endif

    assign bus.Aval  = a_q;
    assign bus.Bval  = b_q;
    assign bus.X     = x_q;
    assign bus.Busy  = (state_q == CLEAR) || (state_q == ADD) || (state_q == SHIFT);
    assign bus.Done  = (state_q == DONE);
    assign bus.State = state_q;
endmodule

// File: doc/shift_add_multiplier.md
# shift_add_multiplier

Parametrised sequential shift-add multiplier: control FSM, iteration counter and {X, A, B} datapath in one block. Replaces the unrolled per-bit state sequence with a counter-driven ADD/SHIFT loop. Supports any operand width and a runtime signed/unsigned mode. Sits between the operand-entry logic (switch/bus loads) and the result display/consumer.

## Interface
- WIDTH, 8, operand width in bits; legal range WIDTH >= 2.
- Clk  in  1  clock; all state changes on its rising edge.
- Reset  in  1  reset, synchronous, active-high.
- LoadA  in  1  load multiplicand register M from Din.
- LoadB  in  1  load multiplier register B from Din; clear A and X.
- Run  in  1  level start request.
- Signed  in  1  1 = two's-complement operands, 0 = unsigned; sampled in CLEAR.
- Din  in  WIDTH  operand input.
- Aval  out  WIDTH  register A (product high half).
- Bval  out  WIDTH  register B (product low half).
- X  out  1  extension bit.
- Busy  out  1  high in CLEAR, ADD, SHIFT.
- Done  out  1  high in DONE.
- State  out  3  encoded FSM state, for debug: IDLE=0, CLEAR=1, ADD=2, SHIFT=3, DONE=4.

## Operation
- Reset: state IDLE; A, B, M, X, count, mode flag = 0; Busy = Done = 0; State = 0.
- IDLE: LoadA/LoadB act; Run = 1 -> CLEAR.
- CLEAR: A = 0, X = 0, count = 0, mode flag latched from Signed -> ADD.
- ADD: if B[0] = 0, A and X hold. If B[0] = 1, form a (WIDTH+1)-bit sum and write A = sum[WIDTH-1:0], X = sum[WIDTH]:
  - Signed: {A[W-1],A} + {M[W-1],M}; on the last iteration (count = WIDTH-1), subtract instead.
  - Unsigned: {0,A} + {0,M}, always add; X takes the carry.
  - ADD always goes to SHIFT.
- SHIFT: A = {X, A[W-1:1]}, B = {A[0], B[W-1:1]}.
  - Signed: X holds (sign replication). Unsigned: X = 0.
  - If count = WIDTH-1 -> DONE; else count + 1 -> ADD.
- DONE: product = {A, B}, 2*WIDTH bits. Run = 0 -> IDLE; Run held high stays in DONE with no restart.
- Loads:
  - LoadA/LoadB are ignored while Busy. They act in IDLE and DONE.
  - Both asserted in the same cycle: both take effect.
  - Load and Run in the same IDLE cycle: load takes effect and CLEAR uses the loaded value.
- Re-run without LoadB multiplies M by the previous low product half held in B (chained multiply).
- Reset mid-operation: the next edge returns to IDLE with every register cleared. No partial result is retained.

## Timing
- Run sampled high in IDLE at edge 0: CLEAR in cycle 1, ADD/SHIFT pairs in cycles 2 .. 2*WIDTH+1, DONE from edge 2*WIDTH+2 (18 cycles for WIDTH = 8).
- All outputs are registered or decoded from state only. No combinational path from inputs to outputs.
- Count width is $clog2(WIDTH); no wrap occurs because the exit test is count = WIDTH-1.

## Configuration
- MULT_SIGNED_EN defined: the Signed input is honoured as described above.
- MULT_SIGNED_EN undefined: Signed is ignored. The mode is always unsigned (add on every iteration, X = carry, X cleared on shift). Port list is unchanged.

## Test plan
- WIDTH=8, Signed=1, M=0xFD (-3), B=0x07, Run -> Done at cycle 18; {A,B}=0xFFEB, X=1.
- WIDTH=8, Signed=0, M=0xFF, B=0xFF -> {A,B}=0xFE01, X=0; with MULT_SIGNED_EN undefined and Signed=1, the same result.
- WIDTH=8, Signed=1, M=0x80, B=0x80 -> {A,B}=0x4000, X=0.
- WIDTH=8, M=0x02, B=0x03, Run -> 0x0006.
  - Hold Run: Done stays high, no restart.
  - Drop Run, raise again -> {A,B}=0x000C.
  - LoadA pulsed mid-run: M is unchanged.
- WIDTH=16, Signed=0, M=0x1234, B=0x0010 -> {A,B}=0x00012340, Done after 34 cycles.
- Reset asserted in cycle 7 of a run -> next edge State=0, A=B=M=X=0, Busy=Done=0. A following Run with fresh loads completes correctly.
